// File: rtl/synth_param_readback.sv
// Synth parameter readback: latches one field of an oscillator or envelope state bus
// and converts it to four BCD digits with a serial shift-and-add-3 converter.
module synth_param_readback #(
    parameter int VALUE_W = 12
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [2:0]         module_select,
    input  logic [3:0]         parameter_select,
    input  logic               start,
    input  logic [43:0]        osca_bus,
    input  logic [43:0]        oscb_bus,
    input  logic [57:0]        adsr1_bus,
    output logic               busy,
    output logic               valid,
    output logic [VALUE_W-1:0] value,
    output logic [15:0]        bcd,
    output logic               invalid
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [VALUE_W-1:0]   sr_q, sr_n;
    logic [15:0]          scratch_q, scratch_n;
    logic [3:0]           cnt_q;
    logic                 last;
    logic [VALUE_W-1:0]   field;
    logic                 sel_invalid;
    logic [43:0]          osc;
    logic [16+VALUE_W-1:0] shifted;

    function automatic logic [15:0] bcd_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Field mux: both oscillators share one layout, so pick the bus first.
    always_comb begin
        field       = '0;
        sel_invalid = 1'b0;
        osc         = (module_select == 3'b001) ? oscb_bus : osca_bus;
        case (module_select)
            3'b000, 3'b001: begin
                case (parameter_select)
                    4'd0:    field = VALUE_W'(osc[2:0]);
                    4'd1:    field = VALUE_W'(osc[4:3]);
                    4'd2:    field = VALUE_W'(osc[11:5]);
                    4'd3:    field = VALUE_W'(osc[19:12]);
                    4'd4:    field = VALUE_W'(osc[24:20]);
                    4'd5:    field = VALUE_W'(osc[27:25]);
                    4'd6:    field = VALUE_W'(osc[34:28]);
                    4'd7:    field = VALUE_W'(osc[41:35]);
                    4'd8:    field = VALUE_W'(osc[43:42]);
                    default: sel_invalid = 1'b1;
                endcase
            end
            3'b010: begin
                case (parameter_select)
                    4'd0:    field = VALUE_W'(adsr1_bus[11:0]);
                    4'd1:    field = VALUE_W'(adsr1_bus[23:12]);
                    4'd2:    field = VALUE_W'(adsr1_bus[30:24]);
                    4'd3:    field = VALUE_W'(adsr1_bus[42:31]);
                    4'd4:    field = VALUE_W'(adsr1_bus[46:43]);
                    4'd5:    field = VALUE_W'(adsr1_bus[50:47]);
                    4'd6:    field = VALUE_W'(adsr1_bus[57:51]);
                    default: sel_invalid = 1'b1;
                endcase
            end
            default: sel_invalid = 1'b1;
        endcase
    end

    assign shifted   = {bcd_adjust(scratch_q), sr_q} << 1;
    assign scratch_n = shifted[16+VALUE_W-1:VALUE_W];
    assign sr_n      = shifted[VALUE_W-1:0];
    assign last      = (cnt_q == 4'(VALUE_W - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            value     <= '0;
            bcd       <= '0;
            invalid   <= 1'b0;
            cnt_q     <= '0;
            scratch_q <= '0;
            sr_q      <= '0;
        end else begin
            state_q <= state_d;
            valid   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q      <= field;
                        value     <= field;
                        invalid   <= sel_invalid;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_n;
                    sr_q      <= sr_n;
                    cnt_q     <= cnt_q + 4'd1;
                    // The last shift's result goes straight to bcd, no extra cycle.
                    if (last) begin
                        bcd   <= scratch_n;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_synth_param_readback.sv
// Directed bench for synth_param_readback: field selection, BCD results, timing,
// invalid selections, in-flight disturbance and reset abort.
module tb_synth_param_readback;

    localparam int VW = 12;

    logic          clk = 1'b0;
    logic          resetn;
    logic [2:0]    module_select;
    logic [3:0]    parameter_select;
    logic          start;
    logic [43:0]   osca_bus, oscb_bus;
    logic [57:0]   adsr1_bus;
    logic          busy, valid, invalid;
    logic [VW-1:0] value;
    logic [15:0]   bcd;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] prev_bcd = '0;

    synth_param_readback #(.VALUE_W(VW)) dut (
        .clk(clk), .resetn(resetn), .module_select(module_select),
        .parameter_select(parameter_select), .start(start),
        .osca_bus(osca_bus), .oscb_bus(oscb_bus), .adsr1_bus(adsr1_bus),
        .busy(busy), .valid(valid), .value(value), .bcd(bcd), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse start for one edge, follow the conversion, check the result after edge k+VW.
    task automatic run_conv(input logic [2:0] ms, input logic [3:0] ps,
                            input logic [31:0] ev, input logic [15:0] eb,
                            input logic ei, input bit disturb);
        module_select    = ms;
        parameter_select = ps;
        start            = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < VW; j++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("valid_early", {31'd0, valid}, 32'd0);
            check("value_run", {20'd0, value}, ev);
            check("bcd_hold", {16'd0, bcd}, {16'd0, prev_bcd});
            if (disturb) begin
                if (j == 2) begin
                    osca_bus         = ~osca_bus;
                    oscb_bus         = ~oscb_bus;
                    adsr1_bus        = ~adsr1_bus;
                    module_select    = 3'b010;
                    parameter_select = 4'd1;
                end
                if (j == 4) start = 1'b1;
                if (j == 5) start = 1'b0;
            end
            tick();
        end
        check("valid_done", {31'd0, valid}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("bcd_done", {16'd0, bcd}, {16'd0, eb});
        check("value_done", {20'd0, value}, ev);
        check("invalid_done", {31'd0, invalid}, {31'd0, ei});
        prev_bcd = eb;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0;
        module_select = '0; parameter_select = '0;
        osca_bus = '0; oscb_bus = '0; adsr1_bus = '0;
        repeat (3) tick();
        check("reset_state", {14'd0, busy, valid, invalid, value, bcd}, 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_quiet", {14'd0, busy, valid, invalid, value, bcd}, 32'd0);
        end

        // OSCA volume = 100 with all neighbouring bits set
        osca_bus = '1;
        osca_bus[41:35] = 7'd100;
        run_conv(3'b000, 4'd7, 32'd100, 16'h0100, 1'b0, 1'b0);
        tick();
        check("valid_one_cycle", {31'd0, valid}, 32'd0);

        // ADSR1 attack = 4095, then OSCB finetune = 255 started back-to-back
        adsr1_bus = '0;
        adsr1_bus[11:0]  = 12'd4095;
        adsr1_bus[42:31] = 12'd777;
        oscb_bus = '0;
        oscb_bus[19:12] = 8'd255;
        oscb_bus[11:5]  = 7'd127;
        oscb_bus[24:20] = 5'd31;
        run_conv(3'b010, 4'd0, 32'd4095, 16'h4095, 1'b0, 1'b0);
        run_conv(3'b001, 4'd3, 32'd255, 16'h0255, 1'b0, 1'b0);
        tick();

        // Other fields: ADSR amount, OSCA octave
        adsr1_bus = '1;
        adsr1_bus[57:51] = 7'd100;
        run_conv(3'b010, 4'd6, 32'd100, 16'h0100, 1'b0, 1'b0);
        tick();
        osca_bus = '1;
        osca_bus[27:25] = 3'd5;
        run_conv(3'b000, 4'd5, 32'd5, 16'h0005, 1'b0, 1'b0);
        tick();

        // Invalid selections with all-ones buses
        osca_bus = '1; oscb_bus = '1; adsr1_bus = '1;
        run_conv(3'b101, 4'd0, 32'd0, 16'h0000, 1'b1, 1'b0);
        tick();
        run_conv(3'b000, 4'd9, 32'd0, 16'h0000, 1'b1, 1'b0);
        tick();
        run_conv(3'b010, 4'd7, 32'd0, 16'h0000, 1'b1, 1'b0);
        tick();

        // Inputs toggled and start re-pulsed during SHIFT: OSCB detune = 99
        oscb_bus = '0;
        oscb_bus[11:5] = 7'd99;
        run_conv(3'b001, 4'd2, 32'd99, 16'h0099, 1'b0, 1'b1);
        for (int i = 0; i < VW + 2; i++) begin
            tick();
            check("no_extra_valid", {31'd0, valid}, 32'd0);
            check("no_restart", {31'd0, busy}, 32'd0);
        end

        // Reset at edge k+5 aborts the conversion
        osca_bus = '0;
        osca_bus[41:35] = 7'd77;
        module_select = 3'b000; parameter_select = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("busy_pre_abort", {31'd0, busy}, 32'd1);
            if (j == 4) resetn = 1'b0;
            tick();
        end
        resetn = 1'b1;
        check("abort_cleared", {14'd0, busy, valid, invalid, value, bcd}, 32'd0);
        for (int i = 0; i < VW + 2; i++) begin
            tick();
            check("abort_no_valid", {31'd0, valid}, 32'd0);
        end
        prev_bcd = '0;
        osca_bus = '0;
        osca_bus[41:35] = 7'd42;
        run_conv(3'b000, 4'd7, 32'd42, 16'h0042, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/synth_param_readback.md
SYNTH_PARAM_READBACK -- requirements
Module: synth_param_readback

Interface
REQ-001 The block SHALL have one parameter: VALUE_W, default 12, the raw value width and shift count. Supported range is 4..13.
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port resetn, input, 1: reset, synchronous, active-low.
REQ-004 Port module_select, input, 3: 000 = OSCA, 001 = OSCB, 010 = ADSR1; all other codes are invalid.
REQ-005 Port parameter_select, input, 4: parameter code within the module (REQ-010, REQ-011).
REQ-006 Port start, input, 1: readback request, sampled at rising edges.
REQ-007 Ports osca_bus and oscb_bus, input, 44 each: packed oscillator state, LSB-first in order wave[3], unison[2], detune[7], finetune[8], semitone[5], octave[3], panning[7], volume[7], output[2].
REQ-008 Port adsr1_bus, input, 58: packed envelope state, LSB-first in order attack[12], decay[12], sustain[7], release[12], target[4], parameter[4], amount[7].
REQ-009 Outputs SHALL be:
- busy, 1: conversion in progress.
- valid, 1: one-cycle result strobe.
- value, VALUE_W: captured raw value.
- bcd, 16: four BCD digits, [15:12] thousands.
- invalid, 1: the captured selection was unmapped.

Function
REQ-010 OSC parameter codes SHALL map 0..8 to wave, unison, detune, finetune, semitone, octave, panning, volume, output; codes 9..15 are invalid.
REQ-011 ADSR parameter codes SHALL map 0..6 to attack, decay, sustain, release, target, parameter, amount; codes 7..15 are invalid.
REQ-012 The selected field SHALL be zero-extended, unsigned, to VALUE_W; an invalid selection SHALL yield 0.
REQ-013 The FSM SHALL have exactly two states, IDLE and SHIFT; the reset state is IDLE.
REQ-014 In IDLE with start=1 at edge k, the block SHALL do the following at edge k:
- capture the selected value into the shift register and into value;
- capture the invalid flag;
- clear the BCD scratch register and the shift counter;
- enter SHIFT and set busy=1.
REQ-015 In IDLE with start=0, all registers SHALL hold.
REQ-016 Each SHIFT edge SHALL first add 3 to every scratch digit that is >=5, then shift {scratch, shift register} left by one bit and increment the counter.
REQ-017 At the VALUE_W-th SHIFT edge (edge k+VALUE_W), the block SHALL:
- load bcd with the final scratch value;
- set valid=1 and busy=0;
- return to IDLE.
REQ-018 valid SHALL be high for exactly one cycle, after edge k+VALUE_W, and cleared at the next edge.
REQ-019 start SHALL be ignored while in SHIFT; bcd, value and invalid are not disturbed by a start in SHIFT.
REQ-020 Select and bus inputs SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the in-flight result.
REQ-021 A start sampled at edge k+VALUE_W+1 SHALL be accepted (back-to-back throughput is one result per VALUE_W+1 cycles).
REQ-022 bcd and invalid SHALL hold the last result until the next completion; value updates at acceptance.

Reset
REQ-023 With resetn=0 at an edge, the block SHALL clear busy, valid, value, bcd, invalid, the counter, the scratch and shift registers, and enter IDLE.
REQ-024 A reset during SHIFT SHALL abort the conversion with no valid pulse; reset has priority over start.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset hold, then release: all outputs 0 and busy=0 for 20 cycles with start=0.
- OSCA volume field=100; select 000/0111 with start pulsed at edge k: busy during k..k+11, valid only after edge k+12, bcd=16'h0100, value=100, invalid=0.
- ADSR1 attack=4095; select 010/0000: bcd=16'h4095; then finetune of OSCB=255 (select 001/0011) started at edge k+13: bcd=16'h0255 at k+25.
- module_select=101, or 000/1001: invalid=1, value=0, bcd=16'h0000, valid pulse at k+12.
- Selects and buses toggled, and start re-pulsed, during SHIFT: result equals the value captured at k, and exactly one valid pulse.
- resetn=0 at edge k+5 of a conversion: no valid pulse, all outputs 0, next start converts normally.
